// File: rtl/hazard_pipe_ctrl_if.sv
// rtl/hazard_pipe_ctrl_if.sv - ID-stage hazard inputs and IF/ID/PC control outputs
interface hazard_pipe_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             ex_memread;
  logic [4:0]       ex_rt;
  logic             id_branch_tk;
  logic             id_jump;
  logic             imem_ready;
  logic             pc_write;
  logic             ifid_load;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             stall_active;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  // Decode/memory side drives the hazard inputs and consumes the controls.
  modport master (
    output id_rs, id_rt, id_uses_rt, ex_memread, ex_rt,
           id_branch_tk, id_jump, imem_ready,
    input  pc_write, ifid_load, ifid_flush, idex_bubble,
           stall_active, stall_count, flush_count
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_memread, ex_rt,
           id_branch_tk, id_jump, imem_ready,
    output pc_write, ifid_load, ifid_flush, idex_bubble,
           stall_active, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_pipe_ctrl.sv
// rtl/hazard_pipe_ctrl.sv - load-use / branch / imem-wait hazard sequencer for IF/ID and PC
module hazard_pipe_ctrl #(
  parameter int LU_STALLS = 1,
  parameter int CNT_W     = 16
) (
  input  logic              clock,
  input  logic              reset,
  hazard_pipe_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_STALL,
    ST_WAIT
  } state_e;

  localparam logic [1:0] LU_REM = 2'(LU_STALLS - 1);

  state_e           state_q, state_d;
  logic [1:0]       rem_q, rem_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic lu, br;
  logic pc_write, ifid_load, ifid_flush, idex_bubble;

  // $zero is never written, so a load targeting it cannot create a hazard.
  assign lu = hz.ex_memread && (hz.ex_rt != 5'd0) &&
              ((hz.ex_rt == hz.id_rs) || (hz.id_uses_rt && (hz.ex_rt == hz.id_rt)));
  assign br = hz.id_branch_tk || hz.id_jump;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN;
      rem_q       <= 2'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    pc_write    = 1'b1;
    ifid_load   = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (!hz.imem_ready) begin
          pc_write    = 1'b0;
          ifid_load   = 1'b0;
          idex_bubble = 1'b1;
          state_d     = ST_WAIT;
        end else if (lu) begin
          // A pending branch is dropped here; ID re-resolves it once the load clears.
          pc_write    = 1'b0;
          ifid_load   = 1'b0;
          idex_bubble = 1'b1;
          rem_d       = LU_REM;
          state_d     = (LU_REM != 2'd0) ? ST_STALL : ST_RUN;
        end else if (br) begin
          ifid_flush  = 1'b1;
        end
      end
      ST_STALL: begin
        pc_write    = 1'b0;
        ifid_load   = 1'b0;
        idex_bubble = 1'b1;
        rem_d       = rem_q - 2'd1;
        if (rem_q <= 2'd1) begin
          state_d = ST_RUN;
        end
      end
      ST_WAIT: begin
        // The ready cycle still holds the pipe; fetch resumes from RUN next cycle.
        pc_write    = 1'b0;
        ifid_load   = 1'b0;
        idex_bubble = 1'b1;
        if (hz.imem_ready) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_write && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (ifid_flush && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  assign hz.pc_write     = pc_write;
  assign hz.ifid_load    = ifid_load;
  assign hz.ifid_flush   = ifid_flush;
  assign hz.idex_bubble  = idex_bubble;
  assign hz.stall_active = (state_q != ST_RUN);
  assign hz.stall_count  = stall_cnt_q;
  assign hz.flush_count  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_pipe_ctrl.sv
// tb/tb_hazard_pipe_ctrl.sv - vector table, corner sequences and random run against a reference model
module tb_hazard_pipe_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_memread, id_branch_tk, id_jump, imem_ready;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  hazard_pipe_ctrl_if #(.CNT_W(16)) if1 ();
  hazard_pipe_ctrl_if #(.CNT_W(16)) if2 ();
  hazard_pipe_ctrl_if #(.CNT_W(2))  if3 ();

  hazard_pipe_ctrl #(.LU_STALLS(1), .CNT_W(16)) dut1 (.clock(clock), .reset(reset), .hz(if1.slave));
  hazard_pipe_ctrl #(.LU_STALLS(2), .CNT_W(16)) dut2 (.clock(clock), .reset(reset), .hz(if2.slave));
  hazard_pipe_ctrl #(.LU_STALLS(3), .CNT_W(2))  dut3 (.clock(clock), .reset(reset), .hz(if3.slave));

  assign if1.id_rs = id_rs;  assign if1.id_rt = id_rt;  assign if1.id_uses_rt = id_uses_rt;
  assign if1.ex_memread = ex_memread;  assign if1.ex_rt = ex_rt;
  assign if1.id_branch_tk = id_branch_tk;  assign if1.id_jump = id_jump;  assign if1.imem_ready = imem_ready;
  assign if2.id_rs = id_rs;  assign if2.id_rt = id_rt;  assign if2.id_uses_rt = id_uses_rt;
  assign if2.ex_memread = ex_memread;  assign if2.ex_rt = ex_rt;
  assign if2.id_branch_tk = id_branch_tk;  assign if2.id_jump = id_jump;  assign if2.imem_ready = imem_ready;
  assign if3.id_rs = id_rs;  assign if3.id_rt = id_rt;  assign if3.id_uses_rt = id_uses_rt;
  assign if3.ex_memread = ex_memread;  assign if3.ex_rt = ex_rt;
  assign if3.id_branch_tk = id_branch_tk;  assign if3.id_jump = id_jump;  assign if3.imem_ready = imem_ready;

  // {pc_write, ifid_load, ifid_flush, idex_bubble, stall_active}
  logic [4:0]  act_bits [3];
  logic [31:0] act_sc   [3];
  logic [31:0] act_fc   [3];
  assign act_bits[0] = {if1.pc_write, if1.ifid_load, if1.ifid_flush, if1.idex_bubble, if1.stall_active};
  assign act_bits[1] = {if2.pc_write, if2.ifid_load, if2.ifid_flush, if2.idex_bubble, if2.stall_active};
  assign act_bits[2] = {if3.pc_write, if3.ifid_load, if3.ifid_flush, if3.idex_bubble, if3.stall_active};
  assign act_sc[0] = 32'(if1.stall_count);  assign act_fc[0] = 32'(if1.flush_count);
  assign act_sc[1] = 32'(if2.stall_count);  assign act_fc[1] = 32'(if2.flush_count);
  assign act_sc[2] = 32'(if3.stall_count);  assign act_fc[2] = 32'(if3.flush_count);

  // Reference model: remaining forced-stall cycles, a waiting-for-imem flag, plain counters.
  int lu_n [3] = '{1, 2, 3};
  int sat  [3] = '{65535, 65535, 3};
  int m_hold [3];
  bit m_wait [3];
  int m_sc   [3];
  int m_fc   [3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit f_lu();
    return ex_memread && (ex_rt != 5'd0) &&
           ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  endfunction

  function automatic logic [4:0] m_exp(input int k);
    bit busy, stall, flush;
    busy  = m_wait[k] || (m_hold[k] > 0);
    stall = busy || !imem_ready || f_lu();
    flush = !stall && (id_branch_tk || id_jump);
    return {!stall, !stall, flush, stall, busy};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_hold[k] = 0; m_wait[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
    end
  endtask

  task automatic model_update(input int k, input logic [4:0] e);
    if (m_wait[k])           m_wait[k] = !imem_ready;
    else if (m_hold[k] > 0)  m_hold[k]--;
    else if (!imem_ready)    m_wait[k] = 1'b1;
    else if (f_lu())         m_hold[k] = lu_n[k] - 1;
    if (!e[4] && m_sc[k] < sat[k]) m_sc[k]++;
    if (e[2]  && m_fc[k] < sat[k]) m_fc[k]++;
  endtask

  // Called at posedge+1 with inputs set; compares at negedge, advances model at posedge.
  task automatic step();
    logic [4:0] e [3];
    @(negedge clock);
    for (int k = 0; k < 3; k++) begin
      e[k] = m_exp(k);
      check($sformatf("model_out[%0d]", k), 32'(act_bits[k]), 32'(e[k]));
      check($sformatf("model_sc[%0d]", k), act_sc[k], 32'(m_sc[k]));
      check($sformatf("model_fc[%0d]", k), act_fc[k], 32'(m_fc[k]));
    end
    @(posedge clock);
    for (int k = 0; k < 3; k++) model_update(k, e[k]);
    #1;
  endtask

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                        input logic mr, input logic [4:0] ert, input logic b,
                        input logic j, input logic rdy);
    id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_memread = mr; ex_rt = ert;
    id_branch_tk = b; id_jump = j; imem_ready = rdy;
  endtask

  typedef struct {
    logic [4:0] rs, rt;
    logic       uses_rt, memread;
    logic [4:0] ex_rt;
    logic       br, jmp, ready;
    logic [4:0] e1, e2;
  } vec_t;

  vec_t tbl [15];

  initial begin
    tbl[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'b11000, 5'b11000};
    tbl[1]  = '{5'd5, 5'd1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 5'b00010, 5'b00010};
    tbl[2]  = '{5'd5, 5'd1, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b1, 5'b11000, 5'b00011};
    tbl[3]  = '{5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'b11100, 5'b11100};
    tbl[4]  = '{5'd5, 5'd2, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 5'b00010, 5'b00010};
    tbl[5]  = '{5'd5, 5'd2, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 5'b11100, 5'b00011};
    tbl[6]  = '{5'd5, 5'd2, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 5'b11100, 5'b11100};
    tbl[7]  = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 5'b11000, 5'b11000};
    tbl[8]  = '{5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1, 5'b00010, 5'b00010};
    tbl[9]  = '{5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1, 5'b11000, 5'b00011};
    tbl[10] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00010, 5'b00010};
    tbl[11] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00011, 5'b00011};
    tbl[12] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00011, 5'b00011};
    tbl[13] = '{5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 5'b00011, 5'b00011};
    tbl[14] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'b11000, 5'b11000};

    reset = 1'b1;
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset_out[%0d]", k), 32'(act_bits[k]), 32'(5'b11000));
      check($sformatf("reset_sc[%0d]", k), act_sc[k], 32'd0);
      check($sformatf("reset_fc[%0d]", k), act_fc[k], 32'd0);
    end
    reset = 1'b0;

    // Multi-cycle vector table: load-use, branch vs hazard priority, $zero, imem wait.
    for (int i = 0; i < 15; i++) begin
      set_in(tbl[i].rs, tbl[i].rt, tbl[i].uses_rt, tbl[i].memread, tbl[i].ex_rt,
             tbl[i].br, tbl[i].jmp, tbl[i].ready);
      #1;
      check($sformatf("tbl%0d_lu1", i), 32'(act_bits[0]), 32'(tbl[i].e1));
      check($sformatf("tbl%0d_lu2", i), 32'(act_bits[1]), 32'(tbl[i].e2));
      step();
    end
    check("tbl_stall_count_lu1", act_sc[0], 32'd7);
    check("tbl_flush_count_lu1", act_fc[0], 32'd3);
    check("tbl_stall_count_lu2", act_sc[1], 32'd10);
    check("tbl_flush_count_lu2", act_fc[1], 32'd2);
    check("tbl_stall_count_sat", act_sc[2], 32'd3);
    check("tbl_flush_count_w2",  act_fc[2], 32'd0);

    // Async reset while dut2 sits in STALL.
    set_in(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1);
    step();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    #1;
    check("pre_reset_stall_active", 32'(if2.stall_active), 32'd1);
    reset = 1'b1;
    #1;
    check("async_reset_out", 32'(act_bits[1]), 32'(5'b11000));
    check("async_reset_sc", act_sc[1], 32'd0);
    check("async_reset_fc", act_fc[1], 32'd0);
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Jump with no hazard right after reset.
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    #1;
    check("jump_out", 32'(act_bits[0]), 32'(5'b11100));
    step();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    #1;
    check("jump_flush_count", act_fc[0], 32'd1);
    check("jump_stall_count", act_sc[0], 32'd0);

    // Randomized run with collisions made likely by narrow register ranges.
    for (int i = 0; i < 600; i++) begin
      set_in(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
             ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 10),
             ($urandom_range(0, 99) < 85));
      step();
    end
    check("rand_stall_sat_w2", act_sc[2], 32'd3);
    check("rand_flush_sat_w2", act_fc[2], 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
